// File: rtl/wb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Purpose  : Wishbone classic single-transfer initiator. Accepts one command
//            on a valid/ready channel, runs one Wishbone read or write with a
//            bus timeout, then returns the result on a valid/ready channel.
// Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  // Wishbone initiator port
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  // status
  output logic        busy
);

  // Wide enough to hold TIMEOUT itself, so the counter never wraps before
  // the terminal comparison is made.
  localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              we_q,    we_d;
  logic [3:0]        sel_q,   sel_d;
  logic [31:0]       adr_q,   adr_d;
  logic [31:0]       wdat_q,  wdat_d;
  logic [31:0]       rdat_q,  rdat_d;
  logic              err_q,   err_d;

  // State and datapath registers; reset returns to IDLE from any state,
  // silently dropping an in-flight transfer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      rdat_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: command capture, ack/timeout resolution, response hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          // Write data only moves on writes so wbm_dat_o keeps the last
          // written value across reads.
          if (cmd_we) begin
            wdat_d = cmd_dat;
          end
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // Ack is tested first so an ack in the final allowed cycle wins.
        if (wbm_ack_i) begin
          rdat_d  = we_q ? 32'h0 : wbm_dat_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            rdat_d  = 32'h0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wbm_cyc_o = (state_q == S_BUS);
  assign wbm_stb_o = (state_q == S_BUS);
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_dat   = rdat_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Purpose  : Self-checking bench for wb_cmd_master with a per-transaction
//            reference model derived from the ack/timeout rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

  localparam int TO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .busy      (busy)
  );

  // One full transaction, entered at a falling edge while the DUT is idle.
  // ack_at: stb cycle (1-based) in which the slave acks; <1 means never.
  // The model: the transfer ends at stb cycle min(ack_at, TO); it is an error
  // only if the ack never arrives within TO cycles; read data returns only
  // for successful reads.
  task automatic run_txn(input string name, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int ack_at,
                         input logic [31:0] rdat, input int bp, input bit hold,
                         input logic [31:0] next_adr);
    int          stb_cnt;
    bit          exp_err;
    int          exp_stb;
    logic [31:0] exp_dat;
    logic [31:0] r;
    exp_err = (ack_at < 1) || (ack_at > TO);
    exp_stb = exp_err ? TO : ack_at;
    exp_dat = (exp_err || we) ? 32'h0 : rdat;

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s issue_ready: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    // Scramble the command inputs so only registered values can match.
    r = $urandom; cmd_valid = 1'b0; cmd_adr = r; cmd_dat = ~r; cmd_sel = r[3:0]; cmd_we = r[4];

    stb_cnt = 0;
    while (wbm_stb_o === 1'b1 && stb_cnt < 100) begin
      stb_cnt++;
      checks++;
      if ({wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, cmd_ready, busy, rsp_valid} !==
          {1'b1, we, sel, adr, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s bus_fields cyc%0d: got cyc=%b we=%b sel=%h adr=%h rdy=%b busy=%b rv=%b want cyc=1 we=%b sel=%h adr=%h rdy=0 busy=1 rv=0",
                 name, stb_cnt, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, cmd_ready, busy, rsp_valid, we, sel, adr);
      end
      if (we) begin
        checks++;
        if (wbm_dat_o !== dat) begin
          errors++;
          $display("FAIL %s wdata cyc%0d: got %h want %h", name, stb_cnt, wbm_dat_o, dat);
        end
      end
      r = $urandom;
      wbm_ack_i = (stb_cnt == ack_at);
      wbm_dat_i = wbm_ack_i ? rdat : r;
      @(negedge wb_clk_i);
    end
    wbm_ack_i = 1'b0;

    checks++;
    if (stb_cnt != exp_stb) begin
      errors++;
      $display("FAIL %s stb_cycles: got %0d want %0d", name, stb_cnt, exp_stb);
    end
    checks++;
    if ({rsp_valid, wbm_cyc_o, rsp_err, rsp_dat} !== {1'b1, 1'b0, exp_err, exp_dat}) begin
      errors++;
      $display("FAIL %s response: got valid=%b cyc=%b err=%b dat=%h want valid=1 cyc=0 err=%b dat=%h",
               name, rsp_valid, wbm_cyc_o, rsp_err, rsp_dat, exp_err, exp_dat);
    end

    // Hold the response; a stray ack with junk data must not disturb it.
    cmd_valid = hold; cmd_we = 1'b0; cmd_adr = next_adr; cmd_sel = 4'hF;
    for (int i = 0; i < bp; i++) begin
      r = $urandom;
      rsp_ready = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = r;
      @(negedge wb_clk_i);
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_stb_o} !== {1'b1, exp_err, exp_dat, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s hold%0d: got valid=%b err=%b dat=%h rdy=%b stb=%b want valid=1 err=%b dat=%h rdy=0 stb=0",
                 name, i, rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_stb_o, exp_err, exp_dat);
      end
    end
    wbm_ack_i = 1'b0;
    rsp_ready = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL %s after_handshake: got valid=%b rdy=%b busy=%b want 0 1 0", name, rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    cmd_sel = 4'h0; rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
         wbm_adr_o, wbm_dat_o, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b rv=%b rd=%h re=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h busy=%b want rdy=1 others 0",
               cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy);
    end
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if ({cmd_ready, busy, wbm_stb_o} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b stb=%b want 1 0 0", cmd_ready, busy, wbm_stb_o);
    end
  endtask

  task automatic test_write_zero_wait();
    run_txn("write0", 1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1, 32'h1111_2222, 0, 1'b0, 32'h0);
  endtask

  task automatic test_read_wait();
    run_txn("read3w", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 4, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b0, 32'h3000_0018, 32'h0, 4'h3, 0, 32'h5555_AAAA, 2, 1'b0, 32'h0);
  endtask

  task automatic test_ack_at_timeout();
    run_txn("ack_last", 1'b0, 32'h3000_001C, 32'h0, 4'hF, TO, 32'h0000_0042, 0, 1'b0, 32'h0);
    run_txn("ack_late", 1'b1, 32'h3000_0020, 32'h0BAD_F00D, 4'hC, TO + 1, 32'h0000_0042, 0, 1'b0, 32'h0);
  endtask

  task automatic test_backpressure();
    run_txn("bp_read", 1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 32'h1234_5678, 5, 1'b1, 32'h3000_0028);
    run_txn("bp_next", 1'b0, 32'h3000_0028, 32'h0, 4'hF, 1, 32'hCAFE_0001, 0, 1'b0, 32'h0);
  endtask

  // rsp_ready tied high, cmd_valid held, zero-wait slave: one acceptance
  // every three cycles.
  task automatic test_back_to_back();
    int acc[$];
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0100; cmd_dat = 32'h0F0F_0F0F;
    cmd_sel = 4'hF; rsp_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (cmd_ready === 1'b1) acc.push_back(i);
      wbm_ack_i = wbm_stb_o;
      @(negedge wb_clk_i);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wbm_ack_i = wbm_stb_o;
      @(negedge wb_clk_i);
    end
    wbm_ack_i = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (acc.size() != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d acceptances want 5", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 3) begin
        errors++;
        $display("FAIL b2b_gap%0d: got %0d want 3", i, acc[i] - acc[i-1]);
      end
    end
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_drain: got rdy=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0200; cmd_sel = 4'hF;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    checks++;
    if (wbm_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_stb1: got %b want 1", wbm_stb_o);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy} !== 5'b00010) begin
      errors++;
      $display("FAIL rstmid_abort: got cyc=%b stb=%b rv=%b rdy=%b busy=%b want 0 0 0 1 0",
               wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wbm_ack_i = 1'b1; wbm_dat_i = 32'hFEED_0000 + 32'(i);
      @(negedge wb_clk_i);
      checks++;
      if ({rsp_valid, wbm_stb_o, busy, cmd_ready, rsp_dat} !== {4'b0001, 32'h0}) begin
        errors++;
        $display("FAIL rstmid_late_ack%0d: got rv=%b stb=%b busy=%b rdy=%b rd=%h want 0 0 0 1 0",
                 i, rsp_valid, wbm_stb_o, busy, cmd_ready, rsp_dat);
      end
    end
    wbm_ack_i = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, m;
    for (int n = 0; n < 24; n++) begin
      a = $urandom; d = $urandom; rd = $urandom; m = $urandom;
      run_txn($sformatf("rand%0d", n), m[0], a, d, m[7:4], $urandom_range(10, 0), rd,
              $urandom_range(3, 0), 1'b0, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_ack_at_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
